// File: rtl/axi_txn_sequencer.sv
// Sequences up to NUM_M AXI4 example masters through their INIT_AXI_TXN / TXN_DONE / ERROR handshake.
// Optional per-transaction watchdog: define AXI_TXN_SEQ_TIMEOUT_EN.
module axi_txn_sequencer #(
    parameter int unsigned NUM_M             = 4,
    parameter int unsigned INIT_PULSE_CYCLES = 2,
    parameter bit          STOP_ON_ERROR     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             seq_start,
    input  logic [NUM_M-1:0] cfg_en_mask,
    input  logic [7:0]       cfg_loops,
    output logic [NUM_M-1:0] M_INIT_AXI_TXN,
    input  logic [NUM_M-1:0] M_TXN_DONE,
    input  logic [NUM_M-1:0] M_ERROR,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             seq_pass,
    output logic [NUM_M-1:0] err_mask,
    output logic [2:0]       cur_idx,
    output logic [7:0]       loop_cnt,
    output logic             timeout_flag
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LOOP_W = 8;
    localparam int unsigned PCNT_W = (INIT_PULSE_CYCLES > 1) ? $clog2(INIT_PULSE_CYCLES) : 1;

    if (NUM_M < 1 || NUM_M > 8 || INIT_PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi_txn_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_PULSE,
        ST_WAIT,
        ST_NEXT,
        ST_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_M-1:0]    en_q, en_d;
    logic [LOOP_W-1:0]   loops_q, loops_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                hist_q, hist_d;
    logic [NUM_M-1:0]    err_q, err_d;
    logic                tflag_q, tflag_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [NUM_M-1:0]    init_q, init_d;

`ifdef AXI_TXN_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    // Only the currently selected master's inputs are looked at.
    logic [NUM_M-1:0] sel_bit;
    logic             en_hit, done_hit, err_hit, last_idx;
    logic             complete, failed;

    assign sel_bit  = NUM_M'(1) << idx_q;
    assign en_hit   = |(en_q & sel_bit);
    assign done_hit = |(M_TXN_DONE & sel_bit);
    assign err_hit  = |(M_ERROR & sel_bit);
    assign last_idx = (idx_q == IDX_W'(NUM_M - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            loops_q <= '0;
            loop_q  <= '0;
            idx_q   <= '0;
            pcnt_q  <= '0;
            hist_q  <= 1'b0;
            err_q   <= '0;
            tflag_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            init_q  <= '0;
`ifdef AXI_TXN_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            loops_q <= loops_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            hist_q  <= hist_d;
            err_q   <= err_d;
            tflag_q <= tflag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            init_q  <= init_d;
`ifdef AXI_TXN_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        loops_d  = loops_q;
        loop_d   = loop_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        hist_d   = hist_q;
        err_d    = err_q;
        tflag_d  = tflag_q;
        done_d   = done_q;
        pass_d   = pass_q;
        complete = 1'b0;
        failed   = 1'b0;
`ifdef AXI_TXN_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (seq_start) begin
                    en_d    = cfg_en_mask;
                    loops_d = (cfg_loops == '0) ? LOOP_W'(1) : cfg_loops;
                    loop_d  = '0;
                    idx_d   = '0;
                    err_d   = '0;
                    tflag_d = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (en_hit) begin
                    pcnt_d  = '0;
                    state_d = ST_PULSE;
                end else if (last_idx) begin
                    state_d = ST_NEXT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PULSE: begin
                // Done level seen at the end of the pulse is the edge-detect history.
                if (pcnt_q == PCNT_W'(INIT_PULSE_CYCLES - 1)) begin
                    hist_d  = done_hit;
                    state_d = ST_WAIT;
`ifdef AXI_TXN_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            ST_WAIT: begin
                hist_d = done_hit;
                if (done_hit && !hist_q) begin
                    complete = 1'b1;
                    failed   = err_hit;
                end
`ifdef AXI_TXN_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    complete = 1'b1;
                    failed   = 1'b1;
                    tflag_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
                if (failed) begin
                    err_d = err_q | sel_bit;
                end
                if (complete) begin
                    if (failed && STOP_ON_ERROR) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = last_idx ? ST_NEXT : ST_SEL;
                    end
                end
            end
            ST_NEXT: begin
                if (9'(loop_q) + 9'd1 == 9'(loops_q)) begin
                    state_d = ST_FIN;
                end else begin
                    loop_d  = loop_q + LOOP_W'(1);
                    idx_d   = '0;
                    state_d = ST_SEL;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status outputs track the state being entered.
        busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
        init_d = (state_d == ST_PULSE) ? (NUM_M'(1) << idx_d) : '0;
        if (state_d == ST_FIN) begin
            done_d = 1'b1;
            pass_d = (err_d == '0) && !tflag_d;
        end
    end

    assign M_INIT_AXI_TXN = init_q;
    assign seq_busy       = busy_q;
    assign seq_done       = done_q;
    assign seq_pass       = pass_q;
    assign err_mask       = err_q;
    assign cur_idx        = idx_q;
    assign loop_cnt       = loop_q;

`ifdef AXI_TXN_SEQ_TIMEOUT_EN
    assign timeout_flag   = tflag_q;
`else
    assign timeout_flag   = 1'b0;
`endif

endmodule

// File: doc/axi_txn_sequencer.md
Name: axi_txn_sequencer

Overview:
- Controller that sequences up to N example AXI4-full master instances through their INIT_AXI_TXN / TXN_DONE / ERROR handshake.
- For each loop, issues an init pulse to each enabled master in turn and waits for that master's completion. Accumulates per-master error status and reports an overall pass/fail.
- Sits beside the block-design wrapper and replaces hand-written init/wait sequencing in system-level benches and self-test builds.

Parameters:
- NUM_M, 4: number of sequenced masters (1..8).
- INIT_PULSE_CYCLES, 2: width of each INIT_AXI_TXN pulse in ACLK cycles (>=1).
- STOP_ON_ERROR, 1: 1 = abort the sequence at the first master reporting ERROR; 0 = run to completion.
- TIMEOUT_CYCLES, 4096: watchdog limit per master transaction (used only with the optional feature).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- seq_start  in  1  single-cycle start request.
- cfg_en_mask  in  NUM_M  masters included in the sequence; sampled on accepted start.
- cfg_loops  in  8  number of passes; 0 is treated as 1; sampled on accepted start.
- M_INIT_AXI_TXN  out  NUM_M  init pulses to the masters.
- M_TXN_DONE  in  NUM_M  done levels from the masters.
- M_ERROR  in  NUM_M  error levels from the masters.
- seq_busy  out  1  sequence in progress.
- seq_done  out  1  sticky completion flag; cleared by the next accepted start.
- seq_pass  out  1  valid when seq_done=1; 1 = no errors and no timeouts.
- err_mask  out  NUM_M  sticky per-master error record.
- cur_idx  out  3  index of the master currently being serviced.
- loop_cnt  out  8  index of the current loop, zero-based.
- timeout_flag  out  1  sticky; set when any master times out.

Behaviour:
- Reset (asynchronous, ARESETN=0): all outputs 0, FSM returns to IDLE. Reset asserted mid-sequence aborts it immediately and drives M_INIT_AXI_TXN low in the same instant.
- FSM states: IDLE, SEL, PULSE, WAIT, NEXT, FIN.
- IDLE:
  - seq_start=1 → latch cfg_en_mask and cfg_loops; clear seq_done, seq_pass, err_mask, timeout_flag; loop_cnt=0, cur_idx=0; go to SEL.
  - seq_start while busy is ignored.
- SEL:
  - Advance cur_idx upward to the first enabled index at or after cur_idx, one index per cycle.
  - Enabled index found → PULSE.
  - No enabled index remains → NEXT.
- PULSE:
  - M_INIT_AXI_TXN[cur_idx]=1 for exactly INIT_PULSE_CYCLES cycles; all other bits stay 0. Then go to WAIT.
  - Capture M_TXN_DONE[cur_idx] in the last PULSE cycle as the edge-detect history.
- WAIT: completion is a 0→1 edge of M_TXN_DONE[cur_idx].
  - A done level that is already high at WAIT entry without a preceding low is not a completion.
  - On the edge cycle, sample M_ERROR[cur_idx]. If it is 1, set err_mask[cur_idx].
  - Edge with error and STOP_ON_ERROR=1 → FIN.
  - Otherwise: cur_idx+1; if cur_idx was NUM_M-1 → NEXT, else → SEL.
- NEXT:
  - loop_cnt+1 == effective loops → FIN.
  - Otherwise loop_cnt+1, cur_idx=0 → SEL.
- FIN: one cycle. seq_done=1; seq_pass = (err_mask==0 && !timeout_flag); seq_busy=0; return to IDLE.
- seq_busy=1 from the cycle after an accepted start until FIN.
- cfg_en_mask==0: no pulses are issued. Each loop performs only the SEL scan, so the sequence reaches FIN after at most loops×(NUM_M+1)+2 cycles with seq_pass=1.
- Outputs of the other masters are ignored while they are not selected.
- Inputs are assumed synchronous to ACLK; no internal synchronizers.
- At most one M_INIT_AXI_TXN bit is high in any cycle.

Optional Feature:
- Macro: AXI_TXN_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: set err_mask[cur_idx] and timeout_flag, then apply the same STOP_ON_ERROR rule as an error.
  - A done edge in the same cycle as expiry takes priority: no timeout is recorded.
- Not defined: no counter; WAIT waits indefinitely; timeout_flag tied 0.

Test Plan:
- NUM_M=4, en_mask=4'b1111, loops=1, each master model returns done 30 cycles after init with no error → pulses issued in order 0,1,2,3, each 2 cycles wide, non-overlapping; seq_done=1, seq_pass=1, err_mask=0.
- en_mask=4'b1010, loops=3 → exactly 6 pulses, order 1,3,1,3,1,3; loop_cnt reads 0,1,2 during the run; pass.
- STOP_ON_ERROR=1, master 1 raises ERROR with done → no pulse to masters 2 or 3; seq_done=1, seq_pass=0, err_mask=4'b0010.
- Stale done: master 0 holds TXN_DONE=1 from a previous run, drops it 5 cycles after init, re-raises it 20 cycles later → exactly one completion recorded, at the re-rise.
- ARESETN=0 during master 2's PULSE → M_INIT_AXI_TXN=0 immediately; all outputs 0. A new start after reset runs cleanly.
- AXI_TXN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, master 0 never completes → timeout recorded after 100 WAIT cycles; timeout_flag=1, err_mask=4'b0001, seq_pass=0.
